fifo_deq_upsizer: RTL

Single-clock width upsizer on the read side of the dual-clock FIFO. Accepts DSIZE-bit beats from the FIFO dequeue interface and packs RATIO consecutive beats into one DSIZE*RATIO-bit word for the wide downstream datapath. A flush handshake emits a partially filled word with a per-lane keep mask. Runs entirely in the FIFO read clock domain.

---
 rtl/fifo_deq_upsizer_pkg.sv | 12 +
 rtl/fifo_deq_upsizer_if.sv | 25 ++
 rtl/fifo_deq_upsizer_out_reg.sv | 35 +++
 rtl/fifo_deq_upsizer.sv | 83 ++++++++
 4 files changed

// File: rtl/fifo_deq_upsizer_pkg.sv
// Shared definitions for the FIFO read-side width converters (upsizer and downsizer).
package fifo_deq_upsizer_pkg;

    localparam int RATIO_MIN = 2;
    localparam int RATIO_MAX = 16;

    // Lane counter width; never collapses to zero bits.
    function automatic int cnt_width(input int ratio);
        return (ratio > 2) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/fifo_deq_upsizer_if.sv
// Beat-in / word-out handshake bundle plus flush request for the read-side upsizer.
interface fifo_deq_upsizer_if #(
    parameter int DSIZE = 8,
    parameter int RATIO = 4
);
    logic [DSIZE-1:0]       enq_bits;
    logic                   enq_valid;
    logic                   enq_ready;
    logic [DSIZE*RATIO-1:0] deq_bits;
    logic [RATIO-1:0]       deq_keep;
    logic                   deq_valid;
    logic                   deq_ready;
    logic                   flush;
    logic                   flush_ack;

    modport slave (
        input  enq_bits, enq_valid, deq_ready, flush,
        output enq_ready, deq_bits, deq_keep, deq_valid, flush_ack
    );

    modport master (
        output enq_bits, enq_valid, deq_ready, flush,
        input  enq_ready, deq_bits, deq_keep, deq_valid, flush_ack
    );
endinterface

// File: rtl/fifo_deq_upsizer_out_reg.sv
// Output word register: loads a packed word + keep mask, holds under backpressure, drops valid on accept.
module upsize_out_reg #(
    parameter int DSIZE = 8,
    parameter int RATIO = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [DSIZE*RATIO-1:0] ld_bits,
    input  logic [RATIO-1:0]       ld_keep,
    input  logic                   deq_ready,
    output logic [DSIZE*RATIO-1:0] deq_bits,
    output logic [RATIO-1:0]       deq_keep,
    output logic                   deq_valid,
    output logic                   out_free
);

    assign out_free = !deq_valid || deq_ready;

    // Caller only raises load when out_free, so a held word is never overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deq_bits  <= '0;
            deq_keep  <= '0;
            deq_valid <= 1'b0;
        end else if (load) begin
            deq_bits  <= ld_bits;
            deq_keep  <= ld_keep;
            deq_valid <= 1'b1;
        end else if (deq_valid && deq_ready) begin
            deq_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_deq_upsizer.sv
// Packs RATIO DSIZE-bit FIFO beats into one wide word; flush emits a partial word with a keep mask.
module fifo_deq_upsizer
    import fifo_deq_upsizer_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int RATIO = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    fifo_deq_upsizer_if.slave             bus,
    output logic [cnt_width(RATIO)-1:0]   lane_cnt
);

    localparam int            CW   = cnt_width(RATIO);
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    if (RATIO < RATIO_MIN || RATIO > RATIO_MAX) begin : g_ratio_check
        $error("fifo_deq_upsizer: RATIO out of range");
    end

    logic [CW-1:0]                 cnt;
    logic [RATIO-1:0][DSIZE-1:0]   lane_q;
    logic [RATIO-1:0][DSIZE-1:0]   ld_word;
    logic [RATIO-1:0]              ld_keep;
    logic                          out_free;
    logic                          last;
    logic                          enq_fire;
    logic                          load;

    assign last          = (cnt == LAST);
    assign bus.enq_ready = out_free || !last;
    assign enq_fire      = bus.enq_valid && bus.enq_ready;
    assign bus.flush_ack = bus.flush && out_free;
    assign lane_cnt      = cnt;

    // Filled lanes come from the accumulator, the incoming beat lands in lane cnt,
    // everything above is forced to zero so stale lane contents never leak out.
    always_comb begin
        ld_word = '0;
        ld_keep = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (CW'(i) < cnt) begin
                ld_word[i] = lane_q[i];
                ld_keep[i] = 1'b1;
            end else if (CW'(i) == cnt && enq_fire) begin
                ld_word[i] = bus.enq_bits;
                ld_keep[i] = 1'b1;
            end
        end
    end

    // A full word and a flush in the same cycle collapse into one emission.
    assign load = (enq_fire && last) || (bus.flush_ack && (enq_fire || cnt != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            lane_q <= '0;
        end else if (load || bus.flush_ack) begin
            cnt <= '0;
        end else if (enq_fire) begin
            lane_q[cnt] <= bus.enq_bits;
            cnt         <= cnt + 1'b1;
        end
    end

    upsize_out_reg #(
        .DSIZE (DSIZE),
        .RATIO (RATIO)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .ld_bits   (ld_word),
        .ld_keep   (ld_keep),
        .deq_ready (bus.deq_ready),
        .deq_bits  (bus.deq_bits),
        .deq_keep  (bus.deq_keep),
        .deq_valid (bus.deq_valid),
        .out_free  (out_free)
    );

endmodule
